// File: rtl/imem_program_loader.sv
// imem_program_loader: framed byte-stream boot loader that fills instruction memory and holds the CPU in reset until the checksum passes
module imem_program_loader #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [63:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        error
);
  localparam int IW = $clog2(DEPTH) + 1;
  typedef enum logic [2:0] {LEN0, LEN1, DATA, CHECK, DONE, ERROR} state_t;
  state_t state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [1:0] lane_q, lane_d;
  logic [31:0] word_q, word_d;
  logic [7:0] xor_q, xor_d;
  logic ready_q, ready_d;
  logic we_q, we_d;
  logic [63:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic cpu_rst_q, cpu_rst_d;
  logic done_q, done_d;
  logic error_q, error_d;
  logic acc;
  logic [15:0] n_w;
  logic last_w;
  assign acc = byte_valid && ready_q;
  assign n_w = {byte_in, len_q[7:0]};
  assign last_w = (16'(idx_q) + 16'd1) == len_q;
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    idx_d = idx_q;
    lane_d = lane_q;
    word_d = word_q;
    xor_d = xor_q;
    we_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (acc) begin
      xor_d = xor_q ^ byte_in;
      case (state_q)
        LEN0: begin
          len_d = {8'h00, byte_in};
          state_d = LEN1;
        end
        LEN1: begin
          len_d = n_w;
          idx_d = '0;
          lane_d = 2'd0;
          state_d = (n_w > 16'(DEPTH)) ? ERROR : (n_w == 16'd0) ? CHECK : DATA;
        end
        DATA: begin
          word_d = {byte_in, word_q[31:8]};
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            we_d = 1'b1;
            waddr_d = {{(62-IW){1'b0}}, idx_q, 2'b00};
            wdata_d = word_d;
            idx_d = idx_q + IW'(1);
            state_d = last_w ? CHECK : DATA;
          end
        end
        CHECK: state_d = (byte_in == xor_q) ? DONE : ERROR;
        default: state_d = state_q;
      endcase
    end
    ready_d = state_d inside {LEN0, LEN1, DATA, CHECK};
    cpu_rst_d = state_d != DONE;
    done_d = state_d == DONE;
    error_d = state_d == ERROR;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LEN0;
      len_q <= '0;
      idx_q <= '0;
      lane_q <= '0;
      word_q <= '0;
      xor_q <= '0;
      ready_q <= 1'b0;
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cpu_rst_q <= 1'b1;
      done_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      idx_q <= idx_d;
      lane_q <= lane_d;
      word_q <= word_d;
      xor_q <= xor_d;
      ready_q <= ready_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
      done_q <= done_d;
      error_q <= error_d;
    end
  end
  assign byte_ready = ready_q;
  assign imem_we = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst = cpu_rst_q;
  assign done = done_q;
  assign error = error_q;
endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader: random and directed frames checked against a frame-level reference model
module tb_imem_program_loader;
  localparam int DEPTH = 64;
  typedef logic [7:0] bq_t[$];
  typedef logic [95:0] wq_t[$];
  logic clk = 1'b0;
  logic rst;
  logic [7:0] byte_in;
  logic byte_valid;
  logic byte_ready;
  logic imem_we;
  logic [63:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic cpu_rst;
  logic done;
  logic error;
  int total = 0;
  int bad = 0;
  wq_t got;
  bq_t fr;
  imem_program_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .byte_in(byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .imem_we(imem_we),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst),
    .done(done),
    .error(error)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (imem_we === 1'b1) got.push_back({imem_waddr, imem_wdata});
  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, byte_ready, 0);
    chk({tag, "_we"}, imem_we, 0);
    chk({tag, "_waddr"}, imem_waddr, 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_cpu_rst"}, cpu_rst, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
  endtask
  task automatic put(input logic [7:0] b, input int gap, input bit need_ready);
    while (int'($urandom_range(99)) < gap) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    if (need_ready) chk("ready_mid_frame", byte_ready, 1);
    byte_in = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask
  task automatic reset_dut();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    got = {};
    @(negedge clk);
  endtask
  task automatic areset(input string tag);
    #2 rst = 1'b1;
    #1 chk_reset_vals(tag);
    @(negedge clk);
    rst = 1'b0;
    got = {};
    @(negedge clk);
    chk({tag, "_ready_after"}, byte_ready, 1);
  endtask
  task automatic make_frame(input int n, input bit corrupt, output bq_t f);
    logic [7:0] x;
    logic [7:0] b;
    f = {};
    f.push_back(n[7:0]);
    f.push_back(n[15:8]);
    x = n[7:0] ^ n[15:8];
    if (n <= DEPTH) begin
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        f.push_back(b);
        x = x ^ b;
      end
      f.push_back(corrupt ? x ^ 8'(1 + $urandom_range(254)) : x);
    end
  endtask
  task automatic model(input bq_t f, output wq_t w, output bit d, output bit e);
    int n;
    int j;
    logic [7:0] x;
    w = {};
    d = 1'b0;
    e = 1'b0;
    n = int'({f[1], f[0]});
    x = f[0] ^ f[1];
    if (n > DEPTH) e = 1'b1;
    else begin
      for (int i = 0; i < n; i++) begin
        j = 2 + 4 * i;
        w.push_back({64'(4 * i), f[j+3], f[j+2], f[j+1], f[j]});
        x = x ^ f[j] ^ f[j+1] ^ f[j+2] ^ f[j+3];
      end
      if (f[2 + 4 * n] == x) d = 1'b1;
      else e = 1'b1;
    end
  endtask
  task automatic run(input bq_t f, input int gap, input string tag);
    wq_t w;
    bit ed;
    bit ee;
    model(f, w, ed, ee);
    for (int i = 0; i < f.size() - 1; i++) put(f[i], gap, 1'b1);
    chk({tag, "_done_before"}, done, 0);
    chk({tag, "_error_before"}, error, 0);
    chk({tag, "_cpu_rst_before"}, cpu_rst, 1);
    put(f[f.size() - 1], gap, 1'b1);
    chk({tag, "_done"}, done, ed);
    chk({tag, "_error"}, error, ee);
    chk({tag, "_cpu_rst"}, cpu_rst, !ed);
    chk({tag, "_ready_end"}, byte_ready, 0);
    repeat (3) put(8'($urandom), 0, 1'b0);
    #1;
    chk({tag, "_done_sticky"}, done, ed);
    chk({tag, "_error_sticky"}, error, ee);
    chk({tag, "_nwrites"}, got.size(), w.size());
    for (int i = 0; i < w.size() && i < got.size(); i++) chk({tag, "_write"}, got[i], w[i]);
    if (w.size() > 0) chk({tag, "_hold"}, {imem_waddr, imem_wdata}, w[w.size() - 1]);
  endtask
  initial begin
    rst = 1'b1;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    @(negedge clk);
    chk_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);
    chk("ready_rise", byte_ready, 1);
    fr = '{8'h01, 8'h00, 8'h20, 8'h00, 8'h02, 8'h8B, 8'hA8};
    run(fr, 0, "one_word");
    if (got.size() > 0) chk("one_word_value", got[0], {64'd0, 32'h8B020020});
    reset_dut();
    make_frame(3, 1'b0, fr);
    run(fr, 30, "three_word_gaps");
    reset_dut();
    fr = '{8'h01, 8'h00, 8'h20, 8'h00, 8'h02, 8'h8B, 8'hA9};
    run(fr, 0, "bad_cksum");
    reset_dut();
    fr = '{8'h41, 8'h00};
    run(fr, 0, "len65");
    reset_dut();
    make_frame(DEPTH, 1'b0, fr);
    run(fr, 10, "len_depth");
    reset_dut();
    fr = '{8'h00, 8'h00, 8'h00};
    run(fr, 0, "empty");
    areset("async_from_done");
    make_frame(3, 1'b0, fr);
    for (int i = 0; i < 4; i++) put(fr[i], 0, 1'b1);
    areset("async_mid_frame");
    run(fr, 20, "after_reset");
    for (int k = 0; k < 6; k++) begin
      reset_dut();
      make_frame(int'($urandom_range(DEPTH + 2)), 1'($urandom_range(1)), fr);
      run(fr, int'($urandom_range(50)), "random");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
